mem_port_arbiter: RTL and testbench

//  Shares one single-ported, fixed-latency memory between instruction fetch (IF) and the data access
//  of the MEM stage. Grants one requester at a time, sequences each access, and returns read data.

---
 rtl/mem_port_arbiter_pkg.sv | 38 +++
 rtl/mem_port_arbiter_lat_counter.sv | 38 +++
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM encodings, grant IDs,
// default latency and the arbitration decision helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY_D = 2'b01,
    ST_BUSY_F = 2'b10
  } arb_state_e;

  typedef enum logic {
    GNT_DATA  = 1'b0,
    GNT_FETCH = 1'b1
  } gnt_e;

  localparam int DEFAULT_LATENCY = 4;
  localparam int CNT_W           = 4;

  // Pick the next owner. When both are pending, the side that did not win
  // last time gets the port so neither requester can starve. Until the very
  // first grant after reset, data wins a tie.
  function automatic gnt_e pick_grant(input logic f_pend,
                                      input logic d_pend,
                                      input gnt_e last,
                                      input logic granted_before);
    gnt_e sel;
    if (f_pend && d_pend) begin
      if (!granted_before) sel = GNT_DATA;
      else                 sel = (last == GNT_DATA) ? GNT_FETCH : GNT_DATA;
    end else if (f_pend) begin
      sel = GNT_FETCH;
    end else begin
      sel = GNT_DATA;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter that times the fixed memory latency. Loaded at the
// grant edge, counts down while an access is in flight, holds 0 when idle.
// done is high in the last in-flight cycle before the data arrives.
module mem_port_arbiter_lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         busy,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: load wins, then decrement while busy, never wraps below 0.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (!busy) begin
      count_d = '0;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign done = busy && (count_q == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, fixed-latency memory between instruction fetch
// and MEM-stage data accesses. One access is in flight at a time; the owner
// gets a one-cycle valid pulse in the completion cycle, with read data passed
// straight through from the memory.
//
// Handshake: a requester holds its req level until it sees its valid pulse.
// Dropping req mid-access is a flush: the access still runs to completion in
// the memory, but no valid is returned. Address/write data are captured at
// the grant edge; later changes on the inputs are ignored for that access.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          dm_rd,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic          fetch_stall,
  output logic          mem_stall,
  output logic [1:0]    dbg_state
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY);

  arb_state_e    state_q, state_d;
  logic          cmpl_q, cmpl_d;          // current cycle is the completion cycle
  gnt_e          last_grant_q, last_grant_d;
  logic          granted_q, granted_d;    // at least one grant since reset
  logic          mem_en_q, mem_en_d;
  logic          mem_wr_q, mem_wr_d;
  logic          acc_wr_q, acc_wr_d;      // in-flight access is a write
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic busy;
  logic can_grant;
  logic f_pend;
  logic d_pend;
  logic grant_fire;
  gnt_e gnt_sel;
  logic cnt_done;
  logic dm_any;

  assign dm_any = dm_rd || dm_wr;

  mem_port_arbiter_lat_counter #(
    .W(CNT_W)
  ) u_lat_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (grant_fire),
    .load_val(LAT_LOAD),
    .busy    (busy),
    .done    (cnt_done)
  );

  // Arbitration and next-state computation. In the completion cycle the
  // owner's own req still refers to the access being finished, so it is
  // masked out; the other requester can be granted with no idle bubble.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    can_grant  = !busy || cmpl_q;
    f_pend     = if_req && !(cmpl_q && (state_q == ST_BUSY_F));
    d_pend     = dm_any && !(cmpl_q && (state_q == ST_BUSY_D));
    grant_fire = can_grant && (f_pend || d_pend);
    gnt_sel    = pick_grant(f_pend, d_pend, last_grant_q, granted_q);

    state_d      = state_q;
    cmpl_d       = cnt_done;
    last_grant_d = last_grant_q;
    granted_d    = granted_q;
    mem_en_d     = 1'b0;
    mem_wr_d     = 1'b0;
    acc_wr_d     = acc_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    if (grant_fire) begin
      granted_d    = 1'b1;
      last_grant_d = gnt_sel;
      mem_en_d     = 1'b1;
      if (gnt_sel == GNT_FETCH) begin
        state_d     = ST_BUSY_F;
        acc_wr_d    = 1'b0;
        mem_addr_d  = if_addr;
        mem_wdata_d = '0;
      end else begin
        // rd and wr together is treated as a write.
        state_d     = ST_BUSY_D;
        acc_wr_d    = dm_wr;
        mem_wr_d    = dm_wr;
        mem_addr_d  = dm_addr;
        mem_wdata_d = dm_wr ? dm_wdata : '0;
      end
    end else if (cmpl_q) begin
      state_d  = ST_IDLE;
      acc_wr_d = 1'b0;
    end
  end

  // FSM and registered memory-side outputs; reset drops any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmpl_q       <= 1'b0;
      last_grant_q <= GNT_DATA;
      granted_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      acc_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cmpl_q       <= cmpl_d;
      last_grant_q <= last_grant_d;
      granted_q    <= granted_d;
      mem_en_q     <= mem_en_d;
      mem_wr_q     <= mem_wr_d;
      acc_wr_q     <= acc_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Completion pulses and read-data passthrough, suppressed after a flush.
  always_comb begin
    if_valid = cmpl_q && (state_q == ST_BUSY_F) && if_req;
    dm_valid = cmpl_q && (state_q == ST_BUSY_D) && dm_any;
    if_rdata = if_valid ? mem_rdata : '0;
    dm_rdata = (dm_valid && !acc_wr_q) ? mem_rdata : '0;
  end

  assign mem_en      = mem_en_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign fetch_stall = if_req && !if_valid;
  assign mem_stall   = dm_any && !dm_valid;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter at LATENCY=4: a per-cycle vector table for the
// single-access and simultaneous-request cases, then hand-written sequences
// for fairness, flush and reset in the middle of an access.
module tb_mem_port_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        dm_rd = 1'b0;
  logic        dm_wr = 1'b0;
  logic [15:0] dm_addr = '0;
  logic [15:0] dm_wdata = '0;
  logic [15:0] mem_rdata;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        if_valid, dm_valid;
  logic [15:0] if_rdata, dm_rdata;
  logic        fetch_stall, mem_stall;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // clock / reset
  always #5 clk = ~clk;

  mem_port_arbiter #(.LATENCY(LAT), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .fetch_stall(fetch_stall), .mem_stall(mem_stall),
    .dbg_state(dbg_state)
  );

  // Memory model: read data is addr ^ 16'hA5A5, presented LAT cycles after
  // the mem_en cycle; garbage otherwise.
  logic        pipe_v [1:LAT];
  logic [15:0] pipe_d [1:LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
    end else begin
      pipe_v[1] <= mem_en;
      pipe_d[1] <= mem_addr ^ 16'hA5A5;
      for (int i = 2; i <= LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end
  assign mem_rdata = pipe_v[LAT] ? pipe_d[LAT] : 16'h0BAD;

  // scoreboard helpers
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic [15:0] fa, input logic r,
                       input logic w, input logic [15:0] da, input logic [15:0] wd);
    if_req = f; if_addr = fa; dm_rd = r; dm_wr = w; dm_addr = da; dm_wdata = wd;
  endtask

  task automatic apply_reset();
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // vector table
  typedef struct {
    logic        do_reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        dm_rd;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        e_en;
    logic        e_wr;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_ifv;
    logic [15:0] e_ifd;
    logic        e_dmv;
    logic [15:0] e_dmd;
    logic        e_fs;
    logic        e_ms;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rs, input logic f, input logic [15:0] fa,
                     input logic r, input logic w, input logic [15:0] da,
                     input logic [15:0] wd, input logic en, input logic wr,
                     input logic [15:0] ea, input logic [15:0] ewd,
                     input logic ifv, input logic [15:0] ifd,
                     input logic dmv, input logic [15:0] dmd,
                     input logic fs, input logic ms);
    vec_t v;
    v.do_reset = rs; v.if_req = f; v.if_addr = fa; v.dm_rd = r; v.dm_wr = w;
    v.dm_addr = da; v.dm_wdata = wd; v.e_en = en; v.e_wr = wr; v.e_addr = ea;
    v.e_wdata = ewd; v.e_ifv = ifv; v.e_ifd = ifd; v.e_dmv = dmv; v.e_dmd = dmd;
    v.e_fs = fs; v.e_ms = ms;
    vq.push_back(v);
  endtask

  initial begin
    // Reset state, with both requests high while in reset.
    drive(1, 16'h1234, 1, 0, 16'h5678, 16'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en",    {15'h0, mem_en},   16'h0);
    chk("rst_mem_wr",    {15'h0, mem_wr},   16'h0);
    chk("rst_mem_addr",  mem_addr,          16'h0);
    chk("rst_mem_wdata", mem_wdata,         16'h0);
    chk("rst_if_valid",  {15'h0, if_valid}, 16'h0);
    chk("rst_dm_valid",  {15'h0, dm_valid}, 16'h0);
    chk("rst_state",     {14'h0, dbg_state}, 16'h0);

    // Lone fetch of 0x0040.
    add(1, 1,16'h0040, 0,0,16'h0,16'h0,  0,0,16'h0,16'h0,     0,16'h0,    0,16'h0, 1,0);
    add(0, 1,16'h0040, 0,0,16'h0,16'h0,  1,0,16'h0040,16'h0,  0,16'h0,    0,16'h0, 1,0);
    add(0, 1,16'h0040, 0,0,16'h0,16'h0,  0,0,16'h0,16'h0,     0,16'h0,    0,16'h0, 1,0);
    add(0, 1,16'h0040, 0,0,16'h0,16'h0,  0,0,16'h0,16'h0,     0,16'h0,    0,16'h0, 1,0);
    add(0, 1,16'h0040, 0,0,16'h0,16'h0,  0,0,16'h0,16'h0,     0,16'h0,    0,16'h0, 1,0);
    add(0, 1,16'h0040, 0,0,16'h0,16'h0,  0,0,16'h0,16'h0,     1,16'hA5E5, 0,16'h0, 0,0);
    add(0, 0,16'h0040, 0,0,16'h0,16'h0,  0,0,16'h0,16'h0,     0,16'h0,    0,16'h0, 0,0);
    // Simultaneous fetch 0x0080 and data read 0x0200: data first.
    add(1, 1,16'h0080, 1,0,16'h0200,16'h0, 0,0,16'h0,16'h0,    0,16'h0,    0,16'h0,    1,1);
    add(0, 1,16'h0080, 1,0,16'h0200,16'h0, 1,0,16'h0200,16'h0, 0,16'h0,    0,16'h0,    1,1);
    add(0, 1,16'h0080, 1,0,16'h0200,16'h0, 0,0,16'h0,16'h0,    0,16'h0,    0,16'h0,    1,1);
    add(0, 1,16'h0080, 1,0,16'h0200,16'h0, 0,0,16'h0,16'h0,    0,16'h0,    0,16'h0,    1,1);
    add(0, 1,16'h0080, 1,0,16'h0200,16'h0, 0,0,16'h0,16'h0,    0,16'h0,    0,16'h0,    1,1);
    add(0, 1,16'h0080, 1,0,16'h0200,16'h0, 0,0,16'h0,16'h0,    0,16'h0,    1,16'hA7A5, 1,0);
    add(0, 1,16'h0080, 0,0,16'h0200,16'h0, 1,0,16'h0080,16'h0, 0,16'h0,    0,16'h0,    1,0);
    add(0, 1,16'h0080, 0,0,16'h0200,16'h0, 0,0,16'h0,16'h0,    0,16'h0,    0,16'h0,    1,0);
    add(0, 1,16'h0080, 0,0,16'h0200,16'h0, 0,0,16'h0,16'h0,    0,16'h0,    0,16'h0,    1,0);
    add(0, 1,16'h0080, 0,0,16'h0200,16'h0, 0,0,16'h0,16'h0,    0,16'h0,    0,16'h0,    1,0);
    add(0, 1,16'h0080, 0,0,16'h0200,16'h0, 0,0,16'h0,16'h0,    1,16'hA525, 0,16'h0,    0,0);
    add(0, 0,16'h0080, 0,0,16'h0200,16'h0, 0,0,16'h0,16'h0,    0,16'h0,    0,16'h0,    0,0);
    // Write 0xBEEF to 0x0100: no read data returned.
    add(1, 0,16'h0, 0,1,16'h0100,16'hBEEF, 0,0,16'h0,16'h0,       0,16'h0, 0,16'h0, 0,1);
    add(0, 0,16'h0, 0,1,16'h0100,16'hBEEF, 1,1,16'h0100,16'hBEEF, 0,16'h0, 0,16'h0, 0,1);
    add(0, 0,16'h0, 0,1,16'h0100,16'hBEEF, 0,0,16'h0,16'h0,       0,16'h0, 0,16'h0, 0,1);
    add(0, 0,16'h0, 0,1,16'h0100,16'hBEEF, 0,0,16'h0,16'h0,       0,16'h0, 0,16'h0, 0,1);
    add(0, 0,16'h0, 0,1,16'h0100,16'hBEEF, 0,0,16'h0,16'h0,       0,16'h0, 0,16'h0, 0,1);
    add(0, 0,16'h0, 0,1,16'h0100,16'hBEEF, 0,0,16'h0,16'h0,       0,16'h0, 1,16'h0, 0,0);
    add(0, 0,16'h0, 0,0,16'h0100,16'hBEEF, 0,0,16'h0,16'h0,       0,16'h0, 0,16'h0, 0,0);
    // rd and wr together behave as a write.
    add(0, 0,16'h0, 1,1,16'h0110,16'h1234, 0,0,16'h0,16'h0,       0,16'h0, 0,16'h0, 0,1);
    add(0, 0,16'h0, 1,1,16'h0110,16'h1234, 1,1,16'h0110,16'h1234, 0,16'h0, 0,16'h0, 0,1);
    add(0, 0,16'h0, 1,1,16'h0110,16'h1234, 0,0,16'h0,16'h0,       0,16'h0, 0,16'h0, 0,1);
    add(0, 0,16'h0, 1,1,16'h0110,16'h1234, 0,0,16'h0,16'h0,       0,16'h0, 0,16'h0, 0,1);
    add(0, 0,16'h0, 1,1,16'h0110,16'h1234, 0,0,16'h0,16'h0,       0,16'h0, 0,16'h0, 0,1);
    add(0, 0,16'h0, 1,1,16'h0110,16'h1234, 0,0,16'h0,16'h0,       0,16'h0, 1,16'h0, 0,0);
    add(0, 0,16'h0, 0,0,16'h0110,16'h1234, 0,0,16'h0,16'h0,       0,16'h0, 0,16'h0, 0,0);

    foreach (vq[k]) begin
      if (vq[k].do_reset) apply_reset();
      drive(vq[k].if_req, vq[k].if_addr, vq[k].dm_rd, vq[k].dm_wr, vq[k].dm_addr, vq[k].dm_wdata);
      @(negedge clk);
      chk($sformatf("v%0d_mem_en", k),   {15'h0, mem_en},      {15'h0, vq[k].e_en});
      chk($sformatf("v%0d_mem_wr", k),   {15'h0, mem_wr},      {15'h0, vq[k].e_wr});
      if (vq[k].e_en) chk($sformatf("v%0d_mem_addr", k), mem_addr, vq[k].e_addr);
      if (vq[k].e_wr) chk($sformatf("v%0d_mem_wdata", k), mem_wdata, vq[k].e_wdata);
      chk($sformatf("v%0d_if_valid", k), {15'h0, if_valid},    {15'h0, vq[k].e_ifv});
      chk($sformatf("v%0d_if_rdata", k), if_rdata,             vq[k].e_ifd);
      chk($sformatf("v%0d_dm_valid", k), {15'h0, dm_valid},    {15'h0, vq[k].e_dmv});
      chk($sformatf("v%0d_dm_rdata", k), dm_rdata,             vq[k].e_dmd);
      chk($sformatf("v%0d_fetch_stall", k), {15'h0, fetch_stall}, {15'h0, vq[k].e_fs});
      chk($sformatf("v%0d_mem_stall", k),   {15'h0, mem_stall},   {15'h0, vq[k].e_ms});
      tick();
    end

    // Fairness: both requests held; grants alternate D,F,D,F every 5 cycles.
    apply_reset();
    drive(1, 16'h0AA0, 1, 0, 16'h0DD0, 16'h0);
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      chk($sformatf("fair_c%0d_mem_en", c), {15'h0, mem_en}, {15'h0, (c % 5) == 1});
      if ((c % 5) == 1)
        chk($sformatf("fair_c%0d_owner_addr", c), mem_addr,
            (((c / 5) % 2) == 0) ? 16'h0DD0 : 16'h0AA0);
      chk($sformatf("fair_c%0d_dm_valid", c), {15'h0, dm_valid},
          {15'h0, (c == 5) || (c == 15)});
      chk($sformatf("fair_c%0d_if_valid", c), {15'h0, if_valid},
          {15'h0, (c == 10) || (c == 20)});
      tick();
    end

    // Flush: fetch dropped at cycle 3; data read pending from cycle 1.
    apply_reset();
    for (int c = 0; c <= 11; c++) begin
      drive(c < 3, 16'h0040, (c >= 1) && (c <= 10), 0, 16'h0300, 16'h0);
      @(negedge clk);
      chk($sformatf("flush_c%0d_if_valid", c), {15'h0, if_valid}, 16'h0);
      chk($sformatf("flush_c%0d_mem_en", c), {15'h0, mem_en}, {15'h0, (c == 1) || (c == 6)});
      if (c == 6) chk("flush_c6_mem_addr", mem_addr, 16'h0300);
      chk($sformatf("flush_c%0d_dm_valid", c), {15'h0, dm_valid}, {15'h0, c == 10});
      if (c == 10) chk("flush_c10_dm_rdata", dm_rdata, 16'hA6A5);
      chk($sformatf("flush_c%0d_fetch_stall", c), {15'h0, fetch_stall}, {15'h0, c < 3});
      tick();
    end

    // Reset during a data read at cycle 2, then a fresh read completes.
    apply_reset();
    drive(0, 16'h0, 1, 0, 16'h0500, 16'h0);
    tick();
    @(negedge clk);
    chk("rmid_grant_mem_en", {15'h0, mem_en}, 16'h1);
    tick();
    rst = 1'b1;
    #1;
    chk("rmid_imm_mem_en",   {15'h0, mem_en},    16'h0);
    chk("rmid_imm_mem_addr", mem_addr,           16'h0);
    chk("rmid_imm_state",    {14'h0, dbg_state}, 16'h0);
    chk("rmid_imm_dm_valid", {15'h0, dm_valid},  16'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rmid_hold%0d_dm_valid", c), {15'h0, dm_valid}, 16'h0);
      chk($sformatf("rmid_hold%0d_mem_en", c),   {15'h0, mem_en},   16'h0);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      drive(0, 16'h0, c <= 5, 0, 16'h0500, 16'h0);
      @(negedge clk);
      chk($sformatf("rmid_r%0d_mem_en", c),   {15'h0, mem_en},   {15'h0, c == 1});
      if (c == 1) chk("rmid_r1_mem_addr", mem_addr, 16'h0500);
      chk($sformatf("rmid_r%0d_dm_valid", c), {15'h0, dm_valid}, {15'h0, c == 5});
      if (c == 5) chk("rmid_r5_dm_rdata", dm_rdata, 16'hA0A5);
      tick();
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
